bias_add_stream: RTL and testbench

Multi-channel, flow-controlled bias adder for the convolution output path. It holds a table of per-kernel bias rows and steps through them one row per output group, marked by `up_last`. It adds the current row lane-wise to a packed stream of CHANNELS signed words. It sits between the accumulator output and the activation stage, and adds valid/ready backpressure, bias storage/sequencing and optional saturation.

---
 rtl/bias_add_stream_pkg.sv | 21 ++
 rtl/bias_add_stream_if.sv | 26 ++
 rtl/bias_add_lane.sv | 48 ++++
 rtl/bias_add_stream.sv | 102 ++++++++++
 tb/tb_bias_add_stream.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bias_add_stream_pkg.sv
// Shared constants and helpers for the bias_add_stream datapath.
// Define BIAS_ADD_SATURATE_EN to clamp lane sums instead of wrapping.
package bias_add_stream_pkg;

  localparam int NUM_WIDTH_D = 16;
  localparam int CHANNELS_D  = 4;
  localparam int DEPTH_D     = 8;

  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

  function automatic logic [63:0] smax(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] smin(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/bias_add_stream_if.sv
// Valid/ready beat stream with a group-end marker.
// Master drives the beat, slave answers with ready.
interface bias_add_stream_if
  import bias_add_stream_pkg::*;
#(
  parameter int DATA_W = CHANNELS_D * NUM_WIDTH_D
);
  logic [DATA_W-1:0] data;
  logic              last;
  logic              valid;
  logic              ready;

  modport master (
    output data,
    output last,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  last,
    input  valid,
    output ready
  );
endinterface

// File: rtl/bias_add_lane.sv
// One lane: registered signed add of data and bias.
// BIAS_ADD_SATURATE_EN selects clamping, otherwise wrap.
module bias_add_lane
  import bias_add_stream_pkg::*;
#(
  parameter int NUM_WIDTH = NUM_WIDTH_D
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [NUM_WIDTH-1:0] i_data,
  input  logic [NUM_WIDTH-1:0] i_bias,
  output logic [NUM_WIDTH-1:0] o_sum
);

  logic [NUM_WIDTH-1:0] w_res;
  logic [NUM_WIDTH-1:0] r_sum;

`ifdef BIAS_ADD_SATURATE_EN
  localparam logic [NUM_WIDTH-1:0] MAXV =
    NUM_WIDTH'(smax(NUM_WIDTH));
  localparam logic [NUM_WIDTH-1:0] MINV =
    NUM_WIDTH'(smin(NUM_WIDTH));

  logic [NUM_WIDTH:0] w_sum;
  logic               w_ovf;

  assign w_sum = {i_data[NUM_WIDTH-1], i_data}
               + {i_bias[NUM_WIDTH-1], i_bias};
  // Sign bit and extra bit disagree only on overflow.
  assign w_ovf = w_sum[NUM_WIDTH] ^ w_sum[NUM_WIDTH-1];
  assign w_res = !w_ovf ? w_sum[NUM_WIDTH-1:0]
               : (w_sum[NUM_WIDTH] ? MINV : MAXV);
`else
  assign w_res = i_data + i_bias;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= w_res;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/bias_add_stream.sv
// Flow-controlled per-group bias adder with a row table.
// BIAS_ADD_SATURATE_EN enables per-lane saturation.
module bias_add_stream
  import bias_add_stream_pkg::*;
#(
  parameter int NUM_WIDTH   = NUM_WIDTH_D,
  parameter int CHANNELS    = CHANNELS_D,
  parameter int DEPTH       = DEPTH_D,
  parameter int DEPTH_WIDTH = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bias_wr,
  input  logic [DEPTH_WIDTH-1:0]        bias_addr,
  input  logic [CHANNELS*NUM_WIDTH-1:0] bias_data,
  input  logic [DEPTH_WIDTH-1:0]        bias_max,
  input  logic                          restart,
  bias_add_stream_if.slave              up,
  bias_add_stream_if.master             dn
);

  localparam int W = CHANNELS * NUM_WIDTH;

  logic [W-1:0]           r_table [DEPTH];
  logic [DEPTH_WIDTH-1:0] r_ptr;
  logic                   r_s1_valid;
  logic                   r_s1_last;
  logic [W-1:0]           r_s1_data;
  logic [W-1:0]           r_s1_bias;
  logic                   r_dn_valid;
  logic                   r_dn_last;
  logic [W-1:0]           w_dn_data;
  logic                   w_adv;
  logic                   w_acc;

  assign w_adv    = !r_dn_valid || dn.ready;
  assign w_acc    = up.valid && w_adv;
  assign up.ready = w_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (bias_wr) begin
      r_table[bias_addr] <= bias_data;
    end
  end

  // restart outranks the group-end step.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_ptr <= '0;
    end else if (w_acc && up.last) begin
      r_ptr <= (r_ptr == bias_max) ? '0 : r_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_data  <= '0;
      r_s1_bias  <= '0;
    end else if (w_adv) begin
      r_s1_valid <= w_acc;
      if (w_acc) begin
        r_s1_last <= up.last;
        r_s1_data <= up.data;
        r_s1_bias <= r_table[r_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dn_valid <= 1'b0;
      r_dn_last  <= 1'b0;
    end else if (w_adv) begin
      r_dn_valid <= r_s1_valid;
      r_dn_last  <= r_s1_last;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    bias_add_lane #(
      .NUM_WIDTH (NUM_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_adv),
      .i_data (r_s1_data[lane_lo(g, NUM_WIDTH) +: NUM_WIDTH]),
      .i_bias (r_s1_bias[lane_lo(g, NUM_WIDTH) +: NUM_WIDTH]),
      .o_sum  (w_dn_data[lane_lo(g, NUM_WIDTH) +: NUM_WIDTH])
    );
  end

  assign dn.data  = w_dn_data;
  assign dn.last  = r_dn_last;
  assign dn.valid = r_dn_valid;

endmodule

// File: tb/tb_bias_add_stream.sv
// Directed vector bench for bias_add_stream.
// Expected overflow results follow BIAS_ADD_SATURATE_EN.
module tb_bias_add_stream;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] din;
    logic         lin;
    logic [W-1:0] dexp;
    logic         lexp;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         bias_wr;
  logic [2:0]   bias_addr;
  logic [W-1:0] bias_data;
  logic [2:0]   bias_max;
  logic         restart;

  bias_add_stream_if #(.DATA_W(W)) up ();
  bias_add_stream_if #(.DATA_W(W)) dn ();

  bias_add_stream u_dut (
    .clk       (clk),
    .rst       (rst),
    .bias_wr   (bias_wr),
    .bias_addr (bias_addr),
    .bias_data (bias_data),
    .bias_max  (bias_max),
    .restart   (restart),
    .up        (up),
    .dn        (dn)
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  vec_t   vec [21];
  beat_t  q [$];
  bit     bp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  logic         p_hold = 1'b0;
  logic [W-1:0] p_data;
  logic         p_last;

  function automatic logic [W-1:0] pk(int a, int b, int c, int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic chk(string n, logic [W-1:0] act, logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic wr(logic [2:0] a, logic [W-1:0] d);
    bias_wr   = 1'b1;
    bias_addr = a;
    bias_data = d;
    tick();
    bias_wr   = 1'b0;
  endtask

  task automatic send(logic [W-1:0] d, logic l);
    bit ok = 1'b0;
    up.valid = 1'b1;
    up.data  = d;
    up.last  = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = up.ready;
      tick();
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no ready expected ready");
    end
  endtask

  task automatic check_q(int first, int n, string name);
    chk({name, "_count"}, W'(q.size()), W'(n));
    for (int i = 0; i < n && i < q.size(); i++) begin
      chk($sformatf("%s_data%0d", name, i), q[i].d, vec[first+i].dexp);
      chk($sformatf("%s_last%0d", name, i), W'(q[i].l),
          W'(vec[first+i].lexp));
    end
    q.delete();
  endtask

  // Records taken beats and checks hold/stall behaviour.
  always @(negedge clk) begin
    if (!rst) begin
      if (p_hold) begin
        chk("hold_valid", W'(dn.valid), W'(1));
        chk("hold_data", dn.data, p_data);
        chk("hold_last", W'(dn.last), W'(p_last));
      end
      if (dn.valid && dn.ready) begin
        q.push_back('{d: dn.data, l: dn.last});
      end
      if (dn.valid && !dn.ready) begin
        chk("stall_up_ready", W'(up.ready), W'(0));
      end
    end
    p_hold = !rst && dn.valid && !dn.ready;
    p_data = dn.data;
    p_last = dn.last;
  end

  initial begin
    rst       = 1'b1;
    bias_wr   = 1'b0;
    bias_addr = '0;
    bias_data = '0;
    bias_max  = '0;
    restart   = 1'b0;
    up.valid  = 1'b0;
    up.data   = '0;
    up.last   = 1'b0;
    dn.ready  = 1'b1;

    for (int k = 0; k < 6; k++) begin
      vec[k].din  = pk(10, 10, 10, 10);
      vec[k].lin  = (k % 2) == 1;
      vec[k].dexp = (k == 2 || k == 3) ? pk(9, 9, 9, 9)
                                       : pk(11, 12, 13, 14);
      vec[k].lexp = (k % 2) == 1;
    end
    for (int k = 0; k < 8; k++) begin
      vec[6+k] = '{pk(100+k, k, k, k), 1'b0,
                   pk(101+k, k+2, k+3, k+4), 1'b0};
    end
`ifdef BIAS_ADD_SATURATE_EN
    vec[14] = '{pk('h7FFF, 'h8000, 'h1234, 0), 1'b0,
                pk('h7FFF, 'h8000, 'h1234, 0), 1'b0};
`else
    vec[14] = '{pk('h7FFF, 'h8000, 'h1234, 0), 1'b0,
                pk('h8000, 'h7FFF, 'h1234, 0), 1'b0};
`endif
    vec[15] = '{'0, 1'b0, pk(1, -1, 0, 0), 1'b0};
    vec[16] = '{'0, 1'b0, pk(50, 50, 50, 50), 1'b0};
    vec[17] = '{'0, 1'b1, pk(50, 50, 50, 50), 1'b1};
    vec[18] = '{'0, 1'b0, pk(50, 50, 50, 50), 1'b0};
    vec[19] = '{pk(3, 4, 5, 6), 1'b1, pk(3, 4, 5, 6), 1'b1};
    vec[20] = '{pk(3, 4, 5, 6), 1'b0, pk(3, 4, 5, 6), 1'b0};

    idle(3);
    rst = 1'b0;
    chk("rst_dn_valid", W'(dn.valid), W'(0));
    chk("rst_dn_data", dn.data, '0);
    chk("rst_dn_last", W'(dn.last), W'(0));
    chk("rst_up_ready", W'(up.ready), W'(1));

    send(pk(5, 0, 0, 0), 1'b0);
    up.valid = 1'b0;
    tick();
    chk("lat_valid", W'(dn.valid), W'(1));
    chk("lat_data", dn.data, pk(5, 0, 0, 0));
    tick();
    q.delete();

    wr(3'd0, pk(1, 2, 3, 4));
    wr(3'd1, pk(-1, -1, -1, -1));
    bias_max = 3'd1;
    for (int k = 0; k < 6; k++) send(vec[k].din, vec[k].lin);
    up.valid = 1'b0;
    idle(4);
    check_q(0, 6, "grp");
    restart = 1'b1;
    tick();
    restart = 1'b0;

    fork
      begin
        for (int k = 6; k < 14; k++) send(vec[k].din, vec[k].lin);
        up.valid = 1'b0;
      end
      begin
        for (int i = 0; i < 24; i++) begin
          dn.ready = bp[i % 4];
          tick();
        end
        dn.ready = 1'b1;
      end
    join
    idle(4);
    check_q(6, 8, "bp");

    wr(3'd0, pk(1, -1, 0, 0));
    send(vec[14].din, vec[14].lin);
    up.valid = 1'b0;
    idle(4);
    check_q(14, 1, "ovf");

    bias_wr   = 1'b1;
    bias_addr = 3'd0;
    bias_data = pk(50, 50, 50, 50);
    send(vec[15].din, vec[15].lin);
    bias_wr = 1'b0;
    send(vec[16].din, vec[16].lin);
    up.valid = 1'b0;
    idle(4);
    check_q(15, 2, "hazard");

    restart = 1'b1;
    send(vec[17].din, vec[17].lin);
    restart = 1'b0;
    send(vec[18].din, vec[18].lin);
    up.valid = 1'b0;
    idle(4);
    check_q(17, 2, "restart");

    send(pk(9, 9, 9, 9), 1'b0);
    send(pk(8, 8, 8, 8), 1'b0);
    up.valid  = 1'b0;
    rst       = 1'b1;
    bias_wr   = 1'b1;
    bias_addr = 3'd1;
    bias_data = pk('h3333, 'h3333, 'h3333, 'h3333);
    tick();
    rst     = 1'b0;
    bias_wr = 1'b0;
    chk("midrst_valid", W'(dn.valid), W'(0));
    chk("midrst_data", dn.data, '0);
    q.delete();
    tick();
    chk("midrst_valid2", W'(dn.valid), W'(0));
    send(vec[19].din, vec[19].lin);
    send(vec[20].din, vec[20].lin);
    up.valid = 1'b0;
    idle(4);
    check_q(19, 2, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
